// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_pipe_stage - RV32I decode register with operand bypass and load-use
// stall; perf counters under DECODE_PIPE_STAGE_PERF_EN.            Rev 1.0
// ----------------------------------------------------------------------------
module decode_pipe_stage #(
    parameter int              XLEN      = 32,
    parameter int              RF_IDX_W  = 5,
    parameter int              NUM_BYP   = 3,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        f_vld,
    output logic                        f_rdy,
    input  logic [XLEN-1:0]             f_instr,
    input  logic [XLEN-1:0]             f_pc,
    input  logic                        flush,
    output logic [RF_IDX_W-1:0]         rs1_idx,
    output logic [RF_IDX_W-1:0]         rs2_idx,
    input  logic [XLEN-1:0]             rs1_data,
    input  logic [XLEN-1:0]             rs2_data,
    input  logic [NUM_BYP-1:0]          byp_vld,
    input  logic [NUM_BYP*RF_IDX_W-1:0] byp_rd,
    input  logic [NUM_BYP-1:0]          byp_pend,
    input  logic [NUM_BYP*XLEN-1:0]     byp_data,
    output logic                        x_vld,
    input  logic                        x_rdy,
    output logic [XLEN-1:0]             x_op1,
    output logic [XLEN-1:0]             x_op2,
    output logic [XLEN-1:0]             x_st_data,
    output logic [XLEN-1:0]             x_pc,
    output logic [XLEN-1:0]             x_br_tgt,
    output logic [3:0]                  x_alu_op,
    output logic [RF_IDX_W-1:0]         x_rd,
    output logic                        x_rd_wen,
    output logic                        x_dmem_vld,
    output logic                        x_dmem_we,
    output logic [1:0]                  x_dmem_len,
    output logic                        x_illegal
`ifdef DECODE_PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 bubble_cnt
`endif
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_R    = 3'd1;
    localparam logic [2:0] FMT_I    = 3'd2;
    localparam logic [2:0] FMT_S    = 3'd3;
    localparam logic [2:0] FMT_B    = 3'd4;
    localparam logic [2:0] FMT_U    = 3'd5;
    localparam logic [2:0] FMT_J    = 3'd6;

    logic            d_vld_q, d_vld_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            use_rs1, use_rs2, is_mem, is_alu, aux_sel;
    logic            rs1_hit, rs2_hit, rs1_pend, rs2_pend;
    logic [XLEN-1:0] rs1_byp, rs2_byp, rs1_val, rs2_val;
    logic            hazard, fire_x;

    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign rs1_idx = RF_IDX_W'(instr_q[19:15]);
    assign rs2_idx = RF_IDX_W'(instr_q[24:20]);
    assign x_rd    = RF_IDX_W'(instr_q[11:7]);

    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OPC_OP:                                          fmt = FMT_R;
            OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYS: fmt = FMT_I;
            OPC_STORE:                                       fmt = FMT_S;
            OPC_BR:                                          fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                              fmt = FMT_U;
            OPC_JAL:                                         fmt = FMT_J;
            default:                                         fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
            FMT_S: imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            FMT_B: imm = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
            FMT_U: imm = {{(XLEN-32){instr_q[31]}}, instr_q[31:12], 12'h000};
            FMT_J: imm = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                          instr_q[20], instr_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // Walk oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        rs1_hit  = 1'b0;
        rs2_hit  = 1'b0;
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        rs1_byp  = '0;
        rs2_byp  = '0;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (byp_vld[i] && (byp_rd[i*RF_IDX_W +: RF_IDX_W] == rs1_idx)) begin
                rs1_hit  = 1'b1;
                rs1_pend = byp_pend[i];
                rs1_byp  = byp_data[i*XLEN +: XLEN];
            end
            if (byp_vld[i] && (byp_rd[i*RF_IDX_W +: RF_IDX_W] == rs2_idx)) begin
                rs2_hit  = 1'b1;
                rs2_pend = byp_pend[i];
                rs2_byp  = byp_data[i*XLEN +: XLEN];
            end
        end
    end

    assign rs1_val = (rs1_idx == '0 || !rs1_hit) ? rs1_data : rs1_byp;
    assign rs2_val = (rs2_idx == '0 || !rs2_hit) ? rs2_data : rs2_byp;

    assign use_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign hazard  = d_vld_q && ((use_rs1 && rs1_idx != '0 && rs1_hit && rs1_pend) ||
                                 (use_rs2 && rs2_idx != '0 && rs2_hit && rs2_pend));

    assign x_vld  = !rst && d_vld_q && !hazard && !flush;
    assign fire_x = x_vld && x_rdy;
    assign f_rdy  = !rst && !flush && (!d_vld_q || fire_x);

    assign x_op1 = (opcode == OPC_AUIPC) ? pc_q :
                   (opcode == OPC_LUI)   ? '0   : rs1_val;
    assign x_op2     = (fmt == FMT_R) ? rs2_val : imm;
    assign x_st_data = rs2_val;
    assign x_pc      = pc_q;
    assign x_br_tgt  = pc_q + imm;

    assign is_alu   = (opcode == OPC_OP) || (opcode == OPC_OPIMM);
    assign aux_sel  = (opcode == OPC_OPIMM && funct3 == 3'b000) ? 1'b0 : instr_q[30];
    assign x_alu_op = is_alu ? {aux_sel, funct3} : 4'd0;

    assign x_illegal  = (fmt == FMT_NONE);
    assign x_rd_wen   = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J)) &&
                        (x_rd != '0);
    assign is_mem     = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign x_dmem_vld = is_mem;
    assign x_dmem_we  = (opcode == OPC_STORE);
    assign x_dmem_len = !is_mem               ? 2'd0 :
                        (funct3[1:0] == 2'b00) ? 2'd1 :
                        (funct3[1:0] == 2'b01) ? 2'd2 : 2'd0;

    always_comb begin
        d_vld_d = d_vld_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            d_vld_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (f_vld && f_rdy) begin
            d_vld_d = 1'b1;
            instr_d = f_instr;
            pc_d    = f_pc;
        end else if (fire_x) begin
            d_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_vld_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            d_vld_q <= d_vld_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

`ifdef DECODE_PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    assign stall_cnt_d  = (hazard && !flush && stall_cnt_q != 32'hFFFF_FFFF) ?
                          stall_cnt_q + 32'd1 : stall_cnt_q;
    assign bubble_cnt_d = (x_rdy && !x_vld && bubble_cnt_q != 32'hFFFF_FFFF) ?
                          bubble_cnt_q + 32'd1 : bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe_stage.sv
`default_nettype none
// tb_decode_pipe_stage: directed and randomized checks of decode_pipe_stage
// against a behavioural decode/handshake model.
module tb_decode_pipe_stage;
    localparam int          XLEN = 32;
    localparam int          RW   = 5;
    localparam int          NB   = 3;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int F_NONE = 0, F_R = 1, F_I = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, f_vld, f_rdy, flush, x_vld, x_rdy;
    logic              x_rd_wen, x_dmem_vld, x_dmem_we, x_illegal;
    logic [31:0]       f_instr, f_pc, rs1_data, rs2_data;
    logic [31:0]       x_op1, x_op2, x_st_data, x_pc, x_br_tgt;
    logic [RW-1:0]     rs1_idx, rs2_idx, x_rd;
    logic [NB-1:0]     byp_vld, byp_pend;
    logic [NB*RW-1:0]  byp_rd;
    logic [NB*XLEN-1:0] byp_data;
    logic [3:0]        x_alu_op;
    logic [1:0]        x_dmem_len;
`ifdef DECODE_PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt, bubble_cnt;
`endif

    decode_pipe_stage dut (
        .clk(clk), .rst(rst), .f_vld(f_vld), .f_rdy(f_rdy), .f_instr(f_instr), .f_pc(f_pc),
        .flush(flush), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .byp_vld(byp_vld), .byp_rd(byp_rd), .byp_pend(byp_pend),
        .byp_data(byp_data), .x_vld(x_vld), .x_rdy(x_rdy), .x_op1(x_op1), .x_op2(x_op2),
        .x_st_data(x_st_data), .x_pc(x_pc), .x_br_tgt(x_br_tgt), .x_alu_op(x_alu_op),
        .x_rd(x_rd), .x_rd_wen(x_rd_wen), .x_dmem_vld(x_dmem_vld), .x_dmem_we(x_dmem_we),
        .x_dmem_len(x_dmem_len), .x_illegal(x_illegal)
`ifdef DECODE_PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state and expected outputs
    logic        m_vld;
    logic [31:0] m_instr, m_pc, m_stall, m_bubble;
    logic        e_hazard, e_x_vld, e_f_rdy, e_wen, e_dvld, e_dwe, e_ill;
    logic [31:0] e_op1, e_op2, e_st, e_tgt;
    logic [3:0]  e_alu;
    logic [1:0]  e_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int fmt_of(input logic [6:0] opc);
        case (opc)
            7'b0110011:                                             return F_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: return F_I;
            7'b0100011:                                             return F_S;
            7'b1100011:                                             return F_B;
            7'b0110111, 7'b0010111:                                 return F_U;
            7'b1101111:                                             return F_J;
            default:                                                return F_NONE;
        endcase
    endfunction

    // Immediates rebuilt with weighted-field arithmetic and two's-complement sign.
    function automatic logic [31:0] ref_imm(input logic [31:0] i, input int fmt);
        int v;
        v = 0;
        case (fmt)
            F_I: begin v = int'(i[31:20]); if (i[31]) v -= 4096; end
            F_S: begin v = int'(i[31:25]) * 32 + int'(i[11:7]); if (i[31]) v -= 4096; end
            F_B: begin
                v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (i[31]) v -= 4096;
            end
            F_U: v = int'(i[31:12]) * 4096;
            F_J: begin
                v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                if (i[31]) v -= 1048576;
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf,
                                            output logic pend);
        pend = 1'b0;
        if (idx == 5'd0) return rf;
        for (int i = 0; i < NB; i++) begin
            if (byp_vld[i] && byp_rd[i*RW +: RW] == idx) begin
                pend = byp_pend[i];
                return byp_data[i*XLEN +: XLEN];
            end
        end
        return rf;
    endfunction

    task automatic model_eval();
        int          fmt;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        p1, p2, mem;
        logic [31:0] v1, v2, imm;
        opc = m_instr[6:0];
        f3  = m_instr[14:12];
        fmt = fmt_of(opc);
        imm = ref_imm(m_instr, fmt);
        v1  = resolve(m_instr[19:15], rs1_data, p1);
        v2  = resolve(m_instr[24:20], rs2_data, p2);
        e_hazard = m_vld && ((fmt inside {F_R, F_I, F_S, F_B} && p1) ||
                             (fmt inside {F_R, F_S, F_B} && p2));
        e_x_vld  = !rst && m_vld && !e_hazard && !flush;
        e_f_rdy  = !rst && !flush && (!m_vld || (e_x_vld && x_rdy));
        e_op1    = (opc == 7'b0010111) ? m_pc : (opc == 7'b0110111) ? 32'd0 : v1;
        e_op2    = (fmt == F_R) ? v2 : imm;
        e_st     = v2;
        e_tgt    = m_pc + imm;
        e_alu    = 4'd0;
        if (opc == 7'b0110011) e_alu = {m_instr[30], f3};
        if (opc == 7'b0010011) e_alu = {(f3 == 3'd0) ? 1'b0 : m_instr[30], f3};
        e_wen    = (fmt inside {F_R, F_I, F_U, F_J}) && (m_instr[11:7] != 5'd0);
        mem      = (opc == 7'b0000011) || (opc == 7'b0100011);
        e_dvld   = mem;
        e_dwe    = (opc == 7'b0100011);
        e_len    = !mem ? 2'd0 : (f3[1:0] == 2'd0) ? 2'd1 : (f3[1:0] == 2'd1) ? 2'd2 : 2'd0;
        e_ill    = (fmt == F_NONE);
    endtask

    task automatic model_update();
        if (rst) begin
            m_vld = 1'b0; m_instr = NOP; m_pc = 32'd0; m_stall = 32'd0; m_bubble = 32'd0;
        end else begin
            if (e_hazard && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (x_rdy && !e_x_vld && m_bubble != 32'hFFFF_FFFF) m_bubble++;
            if (flush) begin
                m_vld = 1'b0; m_instr = NOP;
            end else if (f_vld && e_f_rdy) begin
                m_vld = 1'b1; m_instr = f_instr; m_pc = f_pc;
            end else if (e_x_vld && x_rdy) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        chk("f_rdy", 32'(f_rdy), 32'(e_f_rdy));
        chk("x_vld", 32'(x_vld), 32'(e_x_vld));
        chk("rs1_idx", 32'(rs1_idx), 32'(m_instr[19:15]));
        chk("rs2_idx", 32'(rs2_idx), 32'(m_instr[24:20]));
        chk("x_rd", 32'(x_rd), 32'(m_instr[11:7]));
        chk("x_op1", x_op1, e_op1);
        chk("x_op2", x_op2, e_op2);
        chk("x_st_data", x_st_data, e_st);
        chk("x_pc", x_pc, m_pc);
        chk("x_br_tgt", x_br_tgt, e_tgt);
        chk("x_alu_op", 32'(x_alu_op), 32'(e_alu));
        chk("x_rd_wen", 32'(x_rd_wen), 32'(e_wen));
        chk("x_dmem_vld", 32'(x_dmem_vld), 32'(e_dvld));
        chk("x_dmem_we", 32'(x_dmem_we), 32'(e_dwe));
        chk("x_dmem_len", 32'(x_dmem_len), 32'(e_len));
        chk("x_illegal", 32'(x_illegal), 32'(e_ill));
`ifdef DECODE_PIPE_STAGE_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'b0110111;  1: w[6:0] = 7'b0010111;  2: w[6:0] = 7'b1101111;
            3: w[6:0] = 7'b1100111;  4: w[6:0] = 7'b1100011;  5: w[6:0] = 7'b0000011;
            6: w[6:0] = 7'b0100011;  7: w[6:0] = 7'b0010011;  8: w[6:0] = 7'b0110011;
            9: w[6:0] = 7'b0010011;  10: w[6:0] = 7'b0110011;
            default: w[6:0] = 7'($urandom);
        endcase
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        rst = 1'b1; f_vld = 1'b1; f_instr = 32'h0000_0000; f_pc = 32'h0; flush = 1'b0;
        x_rdy = 1'b1; rs1_data = 32'h0; rs2_data = 32'h0;
        byp_vld = '0; byp_rd = '0; byp_pend = '0; byp_data = '0;
        m_vld = 1'b0; m_instr = NOP; m_pc = 32'd0; m_stall = 32'd0; m_bubble = 32'd0;

        // Reset behaviour
        advance();
        sample();
        chk("rst_f_rdy", 32'(f_rdy), 32'd0);
        chk("rst_x_vld", 32'(x_vld), 32'd0);
        advance();
        rst = 1'b0; f_vld = 1'b0;
        sample();
        chk("reset_x_vld", 32'(x_vld), 32'd0);
        chk("reset_pc", x_pc, 32'd0);
        chk("reset_f_rdy", 32'(f_rdy), 32'd1);
        advance();

        // ADDI x1,x0,5
        f_vld = 1'b1; f_instr = 32'h0050_0093; f_pc = 32'h100; rs2_data = 32'h5A5A;
        sample();
        advance();
        f_vld = 1'b0; x_rdy = 1'b0;
        sample();
        chk("addi_vld", 32'(x_vld), 32'd1);
        chk("addi_op1", x_op1, 32'd0);
        chk("addi_op2", x_op2, 32'd5);
        chk("addi_rd", 32'(x_rd), 32'd1);
        chk("addi_wen", 32'(x_rd_wen), 32'd1);
        chk("addi_alu", 32'(x_alu_op), 32'd0);
        advance();

        // ADD x3,x1,x2 handed over back-to-back, then resolved through the bypass network
        x_rdy = 1'b1; f_vld = 1'b1; f_instr = 32'h0020_81B3; f_pc = 32'h104;
        sample();
        chk("b2b_f_rdy", 32'(f_rdy), 32'd1);
        advance();
        f_vld = 1'b0; x_rdy = 1'b0; rs1_data = 32'h11; rs2_data = 32'h22;
        byp_vld = 3'b111; byp_rd = {5'd2, 5'd1, 5'd1};
        byp_data = {32'hCC, 32'hBB, 32'hAA};
        sample();
        chk("byp_op1", x_op1, 32'hAA);
        chk("byp_op2", x_op2, 32'hCC);
        chk("byp_pc", x_pc, 32'h104);
        x_rdy = 1'b1;
        advance();

        // Load-use stall: ADD x4,x1,x2 with x1 pending for two cycles
        f_vld = 1'b1; f_instr = 32'h0020_8233; f_pc = 32'h108;
        byp_vld = 3'b001; byp_rd = {5'd0, 5'd0, 5'd1}; byp_pend = 3'b001;
        sample();
        advance();
        f_instr = 32'h0010_0093; f_pc = 32'h10C;
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("lu_x_vld", 32'(x_vld), 32'd0);
            chk("lu_f_rdy", 32'(f_rdy), 32'd0);
            advance();
        end
        byp_pend = 3'b000;
        sample();
        chk("lu_issue", 32'(x_vld), 32'd1);
        chk("lu_f_rdy_go", 32'(f_rdy), 32'd1);
`ifdef DECODE_PIPE_STAGE_PERF_EN
        chk("lu_stall_cnt", stall_cnt, 32'd2);
`endif
        advance();

        // X back-pressure for three cycles with fetch offering LW x7,8(x2)
        byp_vld = 3'b000; x_rdy = 1'b0; f_instr = 32'h0081_2383; f_pc = 32'h110;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("bp_f_rdy", 32'(f_rdy), 32'd0);
            chk("bp_pc", x_pc, 32'h10C);
            advance();
        end
        x_rdy = 1'b1;
        sample();
        chk("bp_release", 32'(f_rdy), 32'd1);
        advance();
        x_rdy = 1'b0;
        sample();
        chk("lw_vld", 32'(x_vld), 32'd1);
        chk("lw_pc", x_pc, 32'h110);
        chk("lw_dmem", 32'(x_dmem_vld), 32'd1);
        chk("lw_op2", x_op2, 32'd8);
        advance();

        // Flush while the held LW is stalled on x2
        byp_vld = 3'b001; byp_rd = {5'd0, 5'd0, 5'd2}; byp_pend = 3'b001;
        f_instr = 32'h0020_81B3; f_pc = 32'h200;
        sample();
        chk("fl_stalled", 32'(x_vld), 32'd0);
        advance();
        flush = 1'b1;
        sample();
        chk("fl_f_rdy", 32'(f_rdy), 32'd0);
        advance();
        flush = 1'b0; f_vld = 1'b0;
        sample();
        chk("fl_x_vld", 32'(x_vld), 32'd0);
        chk("fl_nop_rd", 32'(x_rd), 32'd0);
        advance();

        // x0 source with a matching pending entry must neither stall nor bypass
        f_vld = 1'b1; f_instr = 32'h0070_0313; f_pc = 32'h120; x_rdy = 1'b1;
        byp_vld = 3'b001; byp_rd = '0; byp_pend = 3'b001; rs1_data = 32'h1234;
        sample();
        advance();
        f_vld = 1'b0;
        sample();
        chk("x0_vld", 32'(x_vld), 32'd1);
        chk("x0_op1", x_op1, 32'h1234);
        advance();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            f_vld    = ($urandom_range(0, 3) != 0);
            f_instr  = rand_instr();
            f_pc     = $urandom & 32'hFFFF_FFFC;
            flush    = ($urandom_range(0, 15) == 0);
            x_rdy    = ($urandom_range(0, 3) != 0);
            rs1_data = $urandom;
            rs2_data = $urandom;
            for (int i = 0; i < NB; i++) begin
                byp_vld[i]             = $urandom_range(0, 1) == 1;
                byp_pend[i]            = $urandom_range(0, 3) == 0;
                byp_rd[i*RW +: RW]     = 5'($urandom_range(0, 3));
                byp_data[i*XLEN +: XLEN] = $urandom;
            end
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
